// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types for the condition-code unit
package cond_pkg;

    localparam int COND_W = 4;

    typedef enum logic [COND_W-1:0] {
        EQ = 4'd0,
        NE = 4'd1,
        HS = 4'd2,
        LO = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic flags_t pack_flags(input logic v, input logic n,
                                          input logic z, input logic c);
        flags_t f;
        f.v = v;
        f.n = n;
        f.z = z;
        f.c = c;
        return f;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluator
module cond_eval
    import cond_pkg::*;
(
    input  flags_t flags,
    input  cond_e  cond,
    output logic   taken
);

    logic n_eq_v;

    always_comb begin
        n_eq_v = (flags.n == flags.v);
        taken  = 1'b0;
        case (cond)
            EQ:      taken = flags.z;
            NE:      taken = !flags.z;
            HS:      taken = flags.c;
            LO:      taken = !flags.c;
            MI:      taken = flags.n;
            PL:      taken = !flags.n;
            VS:      taken = flags.v;
            VC:      taken = !flags.v;
            HI:      taken = flags.c && !flags.z;
            LS:      taken = !flags.c || flags.z;
            GE:      taken = n_eq_v;
            LT:      taken = !n_eq_v;
            GT:      taken = !flags.z && n_eq_v;
            LE:      taken = flags.z || !n_eq_v;
            AL:      taken = 1'b1;
            NV:      taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flag register plus condition query FSM; COND_FWD_EN enables same-cycle flag forwarding
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic             f_v,
    input  logic             f_n,
    input  logic             f_z,
    input  logic             f_c,
    input  logic             f_clr,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [3:0]       q_cond,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_taken,
    output logic [CNT_W-1:0] taken_cnt
);

    state_e state_q;
    state_e state_d;
    flags_t flags_q;
    flags_t flags_in;
    flags_t eval_flags;
    logic   have_q;
    logic   avail;
    cond_e  cond_q;
    cond_e  eval_cond;
    logic   eval_taken;
    logic   taken_q;
    logic   load_taken;
    logic   latch_cond;
    logic   consume;

    assign flags_in = pack_flags(f_v, f_n, f_z, f_c);

`ifdef COND_FWD_EN
    assign avail      = have_q || f_valid;
    assign eval_flags = f_valid ? flags_in : flags_q;
`else
    assign avail      = have_q;
    assign eval_flags = flags_q;
`endif

    // While waiting, the query input is no longer owned by us; use the latched code.
    assign eval_cond = (state_q == WAIT) ? cond_q : cond_e'(q_cond);

    cond_eval u_eval (
        .flags (eval_flags),
        .cond  (eval_cond),
        .taken (eval_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            have_q  <= 1'b0;
        end else if (f_valid) begin
            flags_q <= flags_in;
            have_q  <= 1'b1;
        end else if (f_clr) begin
            have_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_taken = 1'b0;
        latch_cond = 1'b0;
        q_ready    = 1'b0;
        r_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                q_ready = 1'b1;
                if (q_valid) begin
                    latch_cond = 1'b1;
                    if (avail) begin
                        load_taken = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (avail) begin
                    load_taken = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q  <= EQ;
            taken_q <= 1'b0;
        end else begin
            if (latch_cond) begin
                cond_q <= cond_e'(q_cond);
            end
            if (load_taken) begin
                taken_q <= eval_taken;
            end
        end
    end

    assign r_taken = taken_q;
    assign consume = r_valid && r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
        end else if (consume && taken_q && (taken_cnt != {CNT_W{1'b1}})) begin
            taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - randomized self-checking bench for cond_unit
module tb_cond_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             f_valid = 1'b0;
    logic             f_v = 1'b0;
    logic             f_n = 1'b0;
    logic             f_z = 1'b0;
    logic             f_c = 1'b0;
    logic             f_clr = 1'b0;
    logic             q_valid = 1'b0;
    logic             q_ready;
    logic [3:0]       q_cond = 4'd0;
    logic             r_valid;
    logic             r_ready = 1'b0;
    logic             r_taken;
    logic [CNT_W-1:0] taken_cnt;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_valid   (f_valid),
        .f_v       (f_v),
        .f_n       (f_n),
        .f_z       (f_z),
        .f_c       (f_c),
        .f_clr     (f_clr),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_cond    (q_cond),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_taken   (r_taken),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cur_x = 0;
    logic [31:0] cur_y = 0;
    bit          have = 0;
    int          exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference works on the operands themselves, not on flag bits.
    function automatic logic sub_ovf(input logic [31:0] x, input logic [31:0] y);
        longint sd;
        sd = longint'($signed(x)) - longint'($signed(y));
        return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endfunction

    function automatic logic ref_taken(input logic [3:0] cond, input logic [31:0] x,
                                       input logic [31:0] y);
        logic [31:0] d;
        logic        r;
        d = x - y;
        case (cond)
            4'd0:    r = (x == y);
            4'd1:    r = (x != y);
            4'd2:    r = (x >= y);
            4'd3:    r = (x < y);
            4'd4:    r = d[31];
            4'd5:    r = !d[31];
            4'd6:    r = sub_ovf(x, y);
            4'd7:    r = !sub_ovf(x, y);
            4'd8:    r = (x > y);
            4'd9:    r = (x <= y);
            4'd10:   r = ($signed(x) >= $signed(y));
            4'd11:   r = ($signed(x) < $signed(y));
            4'd12:   r = ($signed(x) > $signed(y));
            4'd13:   r = ($signed(x) <= $signed(y));
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic drive_flags(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d   = x - y;
        f_v = sub_ovf(x, y);
        f_n = d[31];
        f_z = (d == 32'd0);
        f_c = (x >= y);
    endtask

    task automatic write_flags(input logic [31:0] x, input logic [31:0] y, input logic clr);
        f_valid = 1'b1;
        f_clr   = clr;
        drive_flags(x, y);
        @(negedge clk);
        f_valid = 1'b0;
        f_clr   = 1'b0;
        cur_x   = x;
        cur_y   = y;
        have    = 1;
    endtask

    task automatic clear_flags();
        f_clr = 1'b1;
        @(negedge clk);
        f_clr = 1'b0;
        have  = 0;
    endtask

    task automatic consume(input logic exp_t);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("r_valid_drop", {31'd0, r_valid}, 32'd0);
        check("q_ready_back", {31'd0, q_ready}, 32'd1);
        if (exp_t && exp_cnt < CNT_MAX) exp_cnt++;
        check("taken_cnt", {{(32-CNT_W){1'b0}}, taken_cnt}, exp_cnt);
    endtask

    task automatic query(input logic [3:0] cond, input int hold, input bit wr_during);
        logic        exp_t;
        logic [31:0] nx;
        logic [31:0] ny;
        exp_t = ref_taken(cond, cur_x, cur_y);
        check("q_ready_idle", {31'd0, q_ready}, 32'd1);
        q_valid = 1'b1;
        q_cond  = cond;
        @(negedge clk);
        q_valid = 1'b0;
        check("r_valid_lat1", {31'd0, r_valid}, 32'd1);
        check("r_taken", {31'd0, r_taken}, {31'd0, exp_t});
        for (int i = 0; i < hold; i++) begin
            if (wr_during) begin
                nx = $urandom;
                ny = $urandom;
                write_flags(nx, ny, 1'b0);
            end else begin
                @(negedge clk);
            end
            check("hold_r_valid", {31'd0, r_valid}, 32'd1);
            check("hold_r_taken", {31'd0, r_taken}, {31'd0, exp_t});
            check("hold_q_ready", {31'd0, q_ready}, 32'd0);
        end
        consume(exp_t);
    endtask

    task automatic query_wait(input logic [3:0] cond, input logic [31:0] x,
                              input logic [31:0] y, input int gap);
        logic exp_t;
        exp_t   = ref_taken(cond, x, y);
        q_valid = 1'b1;
        q_cond  = cond;
        @(negedge clk);
        q_valid = 1'b0;
        check("wait_r_valid", {31'd0, r_valid}, 32'd0);
        check("wait_q_ready", {31'd0, q_ready}, 32'd0);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("wait_hold_r_valid", {31'd0, r_valid}, 32'd0);
        end
        write_flags(x, y, 1'b0);
`ifdef COND_FWD_EN
        check("wait_fwd_lat1", {31'd0, r_valid}, 32'd1);
`else
        check("wait_lat2_early", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        check("wait_lat2", {31'd0, r_valid}, 32'd1);
`endif
        check("wait_r_taken", {31'd0, r_taken}, {31'd0, exp_t});
        consume(exp_t);
    endtask

    task automatic query_same(input logic [3:0] cond, input logic [31:0] x, input logic [31:0] y);
        logic exp_old;
        logic exp_new;
        logic exp_t;
        bit   had;
        exp_old = ref_taken(cond, cur_x, cur_y);
        exp_new = ref_taken(cond, x, y);
        had     = have;
        q_valid = 1'b1;
        q_cond  = cond;
        f_valid = 1'b1;
        drive_flags(x, y);
        @(negedge clk);
        q_valid = 1'b0;
        f_valid = 1'b0;
        cur_x   = x;
        cur_y   = y;
        have    = 1;
`ifdef COND_FWD_EN
        exp_t = exp_new;
        check("same_fwd_r_valid", {31'd0, r_valid}, 32'd1);
`else
        if (had) begin
            exp_t = exp_old;
            check("same_reg_r_valid", {31'd0, r_valid}, 32'd1);
        end else begin
            exp_t = exp_new;
            check("same_nohave_wait", {31'd0, r_valid}, 32'd0);
            @(negedge clk);
            check("same_nohave_r_valid", {31'd0, r_valid}, 32'd1);
        end
`endif
        check("same_r_taken", {31'd0, r_taken}, {31'd0, exp_t});
        consume(exp_t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        have    = 0;
        exp_cnt = 0;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7fff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'hffff_ffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        @(negedge clk);
        check("rst_q_ready", {31'd0, q_ready}, 32'd1);
        check("rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("rst_r_taken", {31'd0, r_taken}, 32'd0);
        check("rst_taken_cnt", {{(32-CNT_W){1'b0}}, taken_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        write_flags(32'd5, 32'd3, 1'b0);
        query(4'd12, 0, 0);
        query(4'd2, 0, 0);
        query(4'd0, 0, 0);
        check("tp_taken_cnt_2", {{(32-CNT_W){1'b0}}, taken_cnt}, 32'd2);

        write_flags(32'd3, 32'd5, 1'b0);
        query(4'd11, 3, 0);

        do_reset();
        query_wait(4'd0, 32'd7, 32'd7, 3);

        write_flags(32'd5, 32'd3, 1'b0);
        query_same(4'd0, 32'd9, 32'd9);

        write_flags(32'h7fff_ffff, 32'hffff_ffff, 1'b0);
        query(4'd10, 0, 0);
        query(4'd11, 0, 0);
        query(4'd4, 0, 0);

        // Reset while a response is pending.
        write_flags(32'd1, 32'd1, 1'b0);
        q_valid = 1'b1;
        q_cond  = 4'd0;
        @(negedge clk);
        q_valid = 1'b0;
        check("pre_rst_r_valid", {31'd0, r_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("mid_rst_q_ready", {31'd0, q_ready}, 32'd1);
        check("mid_rst_r_taken", {31'd0, r_taken}, 32'd0);
        check("mid_rst_taken_cnt", {{(32-CNT_W){1'b0}}, taken_cnt}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        have    = 0;
        exp_cnt = 0;
        query_wait(4'd14, 32'd4, 32'd2, 1);

        for (int it = 0; it < 200; it++) begin
            x = pick_op();
            y = ($urandom_range(0, 3) == 0) ? x : pick_op();
            case ($urandom_range(0, 9))
                0, 1:    write_flags(x, y, 1'($urandom_range(0, 1)));
                2:       clear_flags();
                3:       query_same(4'($urandom_range(0, 15)), x, y);
                default: begin
                    if (!have) query_wait(4'($urandom_range(0, 15)), x, y, $urandom_range(0, 2));
                    else query(4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
